mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported data memory: round-robin on conflict,
// writes complete in the grant cycle, reads return one cycle later to the owner.
module mem_port_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_core,
   output logic [15:0]       conflict_cnt
);

   typedef enum logic [0:0] {StIdle, StRdWait} state_e;

   state_e      state_q, state_d;
   logic        last_gnt_q, last_gnt_d;
   logic        owner_q, owner_d;
   logic [15:0] cnt_q, cnt_d;
   logic        conflict;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         last_gnt_q <= 1'b1;
         owner_q    <= 1'b0;
         cnt_q      <= 16'h0000;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      conflict   = ((state_q == StIdle) && req0 && req1) ||
                   ((state_q == StRdWait) && (req0 || req1));
      if (conflict && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
      unique case (state_q)
         StIdle: begin
            if (gnt0 || gnt1) begin
               last_gnt_d = gnt1;
               if (mem_rd) begin
                  state_d = StRdWait;
                  owner_d = gnt1;
               end
            end
         end
         StRdWait: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic; everything is forced quiet while reset is held
   always_comb begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      if (!reset) begin
         unique case (state_q)
            StIdle: begin
               if (req0 && req1) begin
                  gnt0 = last_gnt_q;
                  gnt1 = ~last_gnt_q;
               end else begin
                  gnt0 = req0;
                  gnt1 = req1;
               end
               if (gnt0) begin
                  mem_wr    = we0;
                  mem_rd    = ~we0;
                  mem_addr  = addr0;
                  mem_wdata = wdata0;
               end else if (gnt1) begin
                  mem_wr    = we1;
                  mem_rd    = ~we1;
                  mem_addr  = addr1;
                  mem_wdata = wdata1;
               end
            end
            StRdWait: begin
               if (owner_q) begin
                  rvalid1 = 1'b1;
                  rdata1  = mem_rdata;
               end else begin
                  rvalid0 = 1'b1;
                  rdata0  = mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_core   = req0 & ~gnt0;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level transaction model and a scoreboard copy of memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset, mem_clr;
   logic        req0, req1, we0, we1;
   logic [8:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr, mem_rd, stall_core;
   logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [8:0]  mem_addr;
   logic [15:0] conflict_cnt;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(9)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1), .mem_wr(mem_wr), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_core(stall_core), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   // Memory environment: read data appears the cycle after mem_rd
   logic [31:0] mem_arr [512];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 512; i++) mem_arr[i] <= 32'h0;
      end else begin
         if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
         if (mem_rd) mem_rdata <= mem_arr[mem_addr];
      end
   end

   // Transaction model: pending read owner (-1 none), last winner, conflict tally
   logic [31:0] ref_mem [512];
   int          m_pend, m_last, m_cnt;
   logic [31:0] m_pdata;
   logic        e_g0, e_g1, e_wr, e_rd, e_rv0, e_rv1;
   logic [8:0]  e_addr;
   logic [31:0] e_wd, e_rdat0, e_rdat1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Predict and compare this cycle's outputs away from the clock edge
   task automatic settle();
      @(negedge clk);
      {e_g0, e_g1, e_wr, e_rd, e_rv0, e_rv1} = '0;
      e_addr = '0; e_wd = '0; e_rdat0 = '0; e_rdat1 = '0;
      if (!reset) begin
         if (m_pend == 0) begin
            e_rv0 = 1'b1; e_rdat0 = m_pdata;
         end else if (m_pend == 1) begin
            e_rv1 = 1'b1; e_rdat1 = m_pdata;
         end else begin
            if (req0 && req1) begin
               e_g0 = (m_last == 1); e_g1 = !e_g0;
            end else begin
               e_g0 = req0; e_g1 = req1;
            end
            if (e_g0) begin
               e_wr = we0; e_rd = !we0; e_addr = addr0; e_wd = wdata0;
            end else if (e_g1) begin
               e_wr = we1; e_rd = !we1; e_addr = addr1; e_wd = wdata1;
            end
         end
      end
      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("rvalid0", rvalid0, e_rv0);
      chk("rvalid1", rvalid1, e_rv1);
      chk("rdata0", rdata0, e_rdat0);
      chk("rdata1", rdata1, e_rdat1);
      chk("stall_core", stall_core, req0 & !e_g0);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      chk("onehot_gnt", gnt0 & gnt1, 0);
      chk("onehot_mem", mem_wr & mem_rd, 0);
      chk("onehot_rvalid", rvalid0 & rvalid1, 0);
   endtask

   // Advance the model across the clock edge
   task automatic tick();
      if (reset) begin
         m_pend = -1; m_last = 1; m_cnt = 0;
      end else begin
         if (((m_pend < 0) ? (req0 && req1) : (req0 || req1)) && m_cnt < 65535) m_cnt++;
         if (m_pend >= 0) begin
            m_pend = -1;
         end else if (e_g0 || e_g1) begin
            m_last = e_g1 ? 1 : 0;
            if (e_wr) begin
               ref_mem[e_addr] = e_wd;
            end else begin
               m_pend  = m_last;
               m_pdata = ref_mem[e_addr];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      settle(); tick();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
      m_pend = -1; m_last = 1; m_cnt = 0;
      reset = 1'b1; mem_clr = 1'b1;
      req0 = 1'b1; req1 = 1'b0; we0 = 1'b1; we1 = 1'b0;
      addr0 = 9'h005; addr1 = '0; wdata0 = 32'h1234_5678; wdata1 = '0;
      // Reset with a live request: no command issued, stall follows req0
      settle(); tick();
      settle(); tick();
      mem_clr = 1'b0; req0 = 1'b0;
      reset = 1'b0;
      chk("rst_cnt", conflict_cnt, 16'h0000);

      // Single read returns next cycle
      req1 = 1; we1 = 1; addr1 = 9'h010; wdata1 = 32'hDEADBEEF;
      settle(); chk("wr010_gnt1", gnt1, 1); tick();
      req1 = 0;
      req0 = 1; we0 = 0; addr0 = 9'h010;
      settle();
      chk("rd010_gnt0", gnt0, 1);
      chk("rd010_mem_rd", mem_rd, 1);
      chk("rd010_addr", mem_addr, 9'h010);
      tick();
      req0 = 0;
      settle();
      chk("rd010_rvalid0", rvalid0, 1);
      chk("rd010_rdata0", rdata0, 32'hDEADBEEF);
      tick();

      // Conflicting writes from reset: 0, then 1, then 0
      reset_pulse();
      req0 = 1; we0 = 1; addr0 = 9'h001; wdata0 = 32'hAAAA_0001;
      req1 = 1; we1 = 1; addr1 = 9'h002; wdata1 = 32'hBBBB_0002;
      settle(); chk("rr_first_gnt0", gnt0, 1); chk("rr_first_gnt1", gnt1, 0); tick();
      req0 = 0;
      settle(); chk("rr_second_gnt1", gnt1, 1); tick();
      chk("rr_cnt_after_two", conflict_cnt, 16'd1);
      req0 = 1; addr0 = 9'h003; wdata0 = 32'hAAAA_0003;
      addr1 = 9'h004; wdata1 = 32'hBBBB_0004;
      settle(); chk("rr_third_gnt0", gnt0, 1); tick();
      req0 = 0;
      settle(); tick();
      req1 = 0;

      // Core stalled behind an auxiliary read
      req1 = 1; we1 = 0; addr1 = 9'h001;
      settle(); chk("aux_rd_gnt1", gnt1, 1); tick();
      req1 = 0;
      req0 = 1; we0 = 0; addr0 = 9'h002;
      settle();
      chk("rdwait_gnt0", gnt0, 0);
      chk("rdwait_stall", stall_core, 1);
      chk("rdwait_rdata1", rdata1, 32'hAAAA_0001);
      tick();
      settle(); chk("after_wait_gnt0", gnt0, 1); tick();
      req0 = 0;
      chk("rdwait_cnt", conflict_cnt, 16'd3);
      settle(); chk("core_rdata0", rdata0, 32'hBBBB_0002); tick();

      // Reset while a read is outstanding
      req0 = 1; we0 = 0; addr0 = 9'h010;
      settle(); tick();
      req0 = 0;
      reset = 1;
      settle(); chk("rst_rdwait_rvalid0", rvalid0, 0); tick();
      reset = 0;
      settle();
      chk("post_rst_rvalid0", rvalid0, 0);
      chk("post_rst_rvalid1", rvalid1, 0);
      chk("post_rst_cnt", conflict_cnt, 16'd0);
      tick();
      req0 = 1; we0 = 1; addr0 = 9'h020; wdata0 = 32'h0000_0020;
      req1 = 1; we1 = 1; addr1 = 9'h021; wdata1 = 32'h0000_0021;
      settle(); chk("post_rst_conflict_gnt0", gnt0, 1); tick();
      req0 = 0;
      settle(); tick();
      req1 = 0;

      // Saturation of the conflict counter
      reset_pulse();
      req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      for (int i = 0; i < 65540; i++) begin
         settle(); tick();
      end
      chk("cnt_saturated", conflict_cnt, 16'hFFFF);
      req0 = 0; req1 = 0;
      settle(); tick();

      // Random traffic, requests held until granted with occasional drops
      reset_pulse();
      for (int i = 0; i < 3000; i++) begin
         if (!req0 || e_g0) begin
            req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
            addr0 = 9'($urandom_range(0, 15)); wdata0 = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            req0 = 0;
         end
         if (!req1 || e_g1) begin
            req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            addr1 = 9'($urandom_range(0, 15)); wdata1 = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            req1 = 0;
         end
         settle(); tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
